cv32e40x_fencei_sequencer: RTL and testbench
============================================

Name: cv32e40x_fencei_sequencer

Overview:
Sequences the fence.i flush handshake on behalf of the main controller FSM.
- On a start pulse (fence.i retiring in WB), it waits for the data-side OBI bus to drain.
- It then drives the external fencei_flush_req/ack handshake and returns a one-cycle done pulse so the controller can refetch from the next PC.
- It also measures flush latency for performance monitoring.
- It sits between the controller FSM and the core top-level fencei_flush_req_o/fencei_flush_ack_i pins.

Parameters:
CNT_W, 16, width of the saturating flush-latency counter (legal range 4..32)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start_i  input  1  one-cycle request from controller FSM: fence.i valid in WB
kill_i  input  1  abandon a sequence not yet handshaking (debug entry, NMI)
lsu_bus_busy_i  input  1  LSU has outstanding OBI transfers or a non-empty write buffer
fencei_flush_req_o  output  1  flush request to external cache/system
fencei_flush_ack_i  input  1  flush acknowledge from system
busy_o  output  1  sequence in progress; controller holds IF/ID halted
done_o  output  1  one-cycle pulse: flush complete, controller may resume fetch
cycle_cnt_o  output  CNT_W  cycles spent in the last/current sequence

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
- Reset values: state=IDLE, fencei_flush_req_o=0, busy_o=0, done_o=0, cycle_cnt_o=0.
- rst overrides everything, including mid-handshake. If rst is asserted while req=1, req=0 after that edge; the system side must tolerate this.
- FSM states: IDLE, DRAIN, FLUSH, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - start_i=1 and kill_i=0 → FLUSH if lsu_bus_busy_i=0, else DRAIN.
  - start_i together with kill_i → stay IDLE; kill wins.
- DRAIN:
  - kill_i=1 → IDLE, no request issued.
  - else lsu_bus_busy_i=0 → FLUSH.
  - else stay.
- FLUSH:
  - fencei_flush_req_o=1.
  - fencei_flush_ack_i=1 → DONE.
  - kill_i is ignored: the request is never withdrawn before ack.
- DONE: done_o=1 for exactly one cycle → IDLE.
- busy_o = (state != IDLE).
- Latency: start in cycle N with the bus idle → req=1 from N+1. Ack sampled in cycle K → req=0 and done_o=1 at K+1, busy_o=0 at K+2.
- Ack arriving in the same cycle req first rises is valid: a minimum FLUSH dwell of 1 cycle.
- Handshake rules:
  - Ack sampled while not in FLUSH is ignored, and no state change occurs.
  - Ack held high across multiple cycles produces a single DONE.
- start_i while busy_o=1 is ignored; it is not queued. The controller guarantees this cannot occur, and the verification bench asserts it.
- lsu_bus_busy_i toggling during FLUSH has no effect.
- Counter:
  - cycle_cnt_o is cleared to 0 on the edge that accepts start_i (IDLE→DRAIN/FLUSH).
  - It increments by 1 on every edge where the next state is DRAIN, FLUSH or DONE.
  - It saturates at 2^CNT_W−1 with no wrap.
  - It holds its value in IDLE until the next accepted start, including after kill.
  - Counter arithmetic is unsigned, CNT_W bits, with the saturation check before the increment.
- The sequencer never issues two requests for one start. After kill, a new start_i is accepted in the cycle immediately following the return to IDLE.

Test Plan:
- Bus idle, start_i at cycle 10, ack at cycle 14 → req high cycles 11–14; done_o=1 at cycle 15 only; busy_o high 11–15; cycle_cnt_o=5 from cycle 15 on.
- lsu_bus_busy_i high cycles 10–19, start_i at 10, ack asserted 1 cycle after req rises → req rises at 21 (DRAIN 11–20); done_o at 23; cycle_cnt_o=13.
- start_i at 10 with bus busy, kill_i at 13 → req never asserted; busy_o low from 14; done_o never pulses; cycle_cnt_o=3. A new start_i at 14 is accepted.
- In FLUSH, kill_i pulsed and ack withheld 20 cycles, ack held 5 cycles → req stays high until ack; exactly one done_o pulse.
- rst asserted mid-FLUSH → next cycle req=0, busy_o=0, cycle_cnt_o=0. Spurious ack while IDLE causes no output change.
- CNT_W=4, ack withheld 30 cycles → cycle_cnt_o saturates at 15 and holds; done_o still pulses once after ack.

Source files
------------

// File: rtl/cv32e40x_fencei_sequencer_if.sv
// Handshake bundle between the controller FSM, the LSU and the system flush
// pins on one side and the fence.i sequencer on the other.
interface cv32e40x_fencei_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             kill_i;
  logic             lsu_bus_busy_i;
  logic             fencei_flush_req_o;
  logic             fencei_flush_ack_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  modport master (
    output start_i, kill_i, lsu_bus_busy_i, fencei_flush_ack_i,
    input  fencei_flush_req_o, busy_o, done_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, kill_i, lsu_bus_busy_i, fencei_flush_ack_i,
    output fencei_flush_req_o, busy_o, done_o, cycle_cnt_o
  );
endinterface

// File: rtl/cv32e40x_fencei_sequencer.sv
// fence.i sequencer: drains the data bus, runs the flush req/ack handshake,
// pulses done and records the flush latency in a saturating counter.
module cv32e40x_fencei_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cv32e40x_fencei_sequencer_if.slave   seq_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    FLUSH = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (seq_if.start_i && !seq_if.kill_i) begin
          state_d = seq_if.lsu_bus_busy_i ? DRAIN : FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (seq_if.kill_i) begin
          state_d = IDLE;
        end else if (!seq_if.lsu_bus_busy_i) begin
          state_d = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      // Once the request is up it stays up until ack; kill is not honoured.
      FLUSH: begin
        if (seq_if.fencei_flush_ack_i) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The accepting edge both clears and counts itself, hence the load of 1.
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      cnt_d = CNT_ONE;
    end else if ((state_d != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign seq_if.fencei_flush_req_o = (state_q == FLUSH);
  assign seq_if.done_o             = (state_q == DONE);
  assign seq_if.busy_o             = (state_q != IDLE);
  assign seq_if.cycle_cnt_o        = cnt_q;

endmodule

// File: tb/tb_cv32e40x_fencei_sequencer.sv
// Randomized scoreboard bench: each sequence's expected outcome is computed
// arithmetically when issued and checked when the DUT drops busy.
module tb_cv32e40x_fencei_sequencer;

  typedef struct {
    int done;
    int req_first;
    int req_len;
    int span;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start_s, kill_s, bb_s, ack_s;

  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;
  int   last_cnt = 0;
  exp_t sb_q[$];

  int   mon_span, mon_req_len, mon_req_first, mon_done_cnt, mon_done_off;
  bit   mon_prev_busy;

  cv32e40x_fencei_sequencer_if #(.CNT_W(16)) if16 ();
  cv32e40x_fencei_sequencer_if #(.CNT_W(4))  if4 ();

  assign if16.start_i            = start_s;
  assign if16.kill_i             = kill_s;
  assign if16.lsu_bus_busy_i     = bb_s;
  assign if16.fencei_flush_ack_i = ack_s;
  assign if4.start_i             = start_s;
  assign if4.kill_i              = kill_s;
  assign if4.lsu_bus_busy_i      = bb_s;
  assign if4.fencei_flush_ack_i  = ack_s;

  cv32e40x_fencei_sequencer #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .seq_if(if16.slave));
  cv32e40x_fencei_sequencer #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .seq_if(if4.slave));

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: accumulate one busy span, then score it against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (if16.busy_o) begin
      if (if16.fencei_flush_req_o) begin
        if (mon_req_len == 0) mon_req_first = mon_span;
        mon_req_len++;
      end
      if (if16.done_o) begin
        mon_done_cnt++;
        mon_done_off = mon_span;
      end
      mon_span++;
      if (start_s) begin
        errors++;
        $display("FAIL start_while_busy: got start=1 busy=1 required start=0");
      end
    end else begin
      if (if16.fencei_flush_req_o || if16.done_o) stray++;
      if (mon_prev_busy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("span_len", mon_span, e.span);
          check("done_count", mon_done_cnt, e.done);
          check("req_len", mon_req_len, e.req_len);
          check("cnt16", int'(if16.cycle_cnt_o), sat(e.cnt, 16));
          check("cnt4", int'(if4.cycle_cnt_o), sat(e.cnt, 4));
          if (e.req_len > 0) check("req_first", mon_req_first, e.req_first);
          if (e.done > 0) check("done_off", mon_done_off, e.span - 1);
        end
        mon_span = 0; mon_req_len = 0; mon_req_first = -1;
        mon_done_cnt = 0; mon_done_off = -1;
      end
    end
    mon_prev_busy = if16.busy_o;
  end

  // d: busy cycles from start, kc: drain cycle carrying kill (0 = none),
  // a: ack delay after req rises, h: ack hold length, fk: force kill in FLUSH.
  task automatic run_txn(input int d, input int kc, input int a, input int h, input bit fk);
    exp_t e;
    int r, len;
    r = d + 1;
    if (kc > 0) begin
      len = kc + 1;
      e = '{done: 0, req_first: -1, req_len: 0, span: kc, cnt: kc};
    end else begin
      len = (r + a + h > r + a + 2) ? r + a + h : r + a + 2;
      e = '{done: 1, req_first: d, req_len: a + 1, span: r + a + 1, cnt: r + a + 1};
    end
    sb_q.push_back(e);
    last_cnt = e.cnt;
    for (int c = 0; c < len; c++) begin
      start_s = (c == 0);
      if (c < d)       bb_s = 1'b1;
      else if (c == d) bb_s = 1'b0;
      else             bb_s = 1'($urandom_range(1, 0));
      if (kc > 0)                   kill_s = (c == kc);
      else if (c >= r && c <= r + a) kill_s = (fk && c == r) || ($urandom_range(2, 0) == 0);
      else                           kill_s = 1'b0;
      if (c < r)             ack_s = (kc > 0 || c < d + 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      else if (kc == 0)      ack_s = (c >= r + a) && (c < r + a + h);
      else                   ack_s = 1'b0;
      tick();
    end
    start_s = 1'b0; kill_s = 1'b0; ack_s = 1'b0;
  endtask

  task automatic run_rst(input int m);
    sb_q.push_back('{done: 0, req_first: 0, req_len: m + 1, span: m + 1, cnt: 0});
    last_cnt = 0;
    start_s = 1'b1; kill_s = 1'b0; bb_s = 1'b0; ack_s = 1'b0;
    tick();
    start_s = 1'b0;
    for (int c = 1; c <= m; c++) begin
      kill_s = 1'($urandom_range(1, 0));
      bb_s   = 1'($urandom_range(1, 0));
      tick();
    end
    kill_s = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // start together with kill, then a lone ack: neither may disturb IDLE.
  task automatic idle_probe();
    start_s = 1'b1; kill_s = 1'b1; ack_s = 1'b1; bb_s = 1'($urandom_range(1, 0));
    tick();
    start_s = 1'b0; kill_s = 1'b0; ack_s = 1'b1;
    tick();
    ack_s = 1'b0;
    @(negedge clk);
    check("probe_busy", int'(if16.busy_o), 0);
    check("probe_req", int'(if16.fencei_flush_req_o), 0);
    check("probe_cnt16", int'(if16.cycle_cnt_o), sat(last_cnt, 16));
    check("probe_cnt4", int'(if4.cycle_cnt_o), sat(last_cnt, 4));
    tick();
  endtask

  initial begin
    int d, kc, a, h;
    mon_span = 0; mon_req_len = 0; mon_req_first = -1;
    mon_done_cnt = 0; mon_done_off = -1; mon_prev_busy = 1'b0;
    rst = 1'b1; start_s = 1'b0; kill_s = 1'b0; bb_s = 1'b0; ack_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", int'(if16.fencei_flush_req_o), 0);
    check("rst_busy", int'(if16.busy_o), 0);
    check("rst_done", int'(if16.done_o), 0);
    check("rst_cnt16", int'(if16.cycle_cnt_o), 0);
    check("rst_cnt4", int'(if4.cycle_cnt_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    run_txn(0, 0, 3, 1, 1'b0);
    run_txn(10, 0, 1, 1, 1'b0);
    run_txn(5, 3, 0, 1, 1'b0);
    run_txn(0, 0, 3, 1, 1'b0);
    run_txn(0, 0, 20, 5, 1'b1);
    run_rst(4);
    idle_probe();
    run_txn(2, 0, 30, 3, 1'b1);
    idle_probe();

    for (int i = 0; i < 40; i++) begin
      d  = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(8, 1));
      kc = (d > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(d, 1)) : 0;
      a  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(35, 16)) : int'($urandom_range(8, 0));
      h  = int'($urandom_range(5, 1));
      run_txn(d, kc, a, h, 1'b0);
      if (i % 8 == 7) idle_probe();
      if (i % 13 == 12) run_rst(int'($urandom_range(6, 0)));
      repeat ($urandom_range(3, 0)) begin
        bb_s = 1'($urandom_range(1, 0));
        tick();
      end
    end

    repeat (5) tick();
    check("sb_empty", sb_q.size(), 0);
    check("stray_outputs", stray, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
